// File: rtl/gsram_result_reader.sv
// Sweeps the 10x10 GSRAM row-major, streams every score on a valid/ready port
// and emits one signed argmax (predicted class) per row.
module gsram_result_reader #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 10,
    parameter int COLS   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              gsram_rd_en,
    output logic [3:0]        gsram_addr_row,
    output logic [3:0]        gsram_addr_col,
    input  logic [DATA_W-1:0] gsram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col,
    output logic              out_last,
    output logic              class_valid,
    output logic [3:0]        class_row,
    output logic [3:0]        class_idx,
    output logic [DATA_W-1:0] class_score
);

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        CLASS,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [3:0]               row;
    logic [3:0]               col;
    logic signed [DATA_W-1:0] max_q;
    logic [3:0]               idx_q;
    logic                     handshake;

    assign handshake = (state == SEND) && out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = SEND;
            SEND: begin
                if (out_ready) state_nx = (col == LAST_COL) ? CLASS : ISSUE;
            end
            CLASS:   state_nx = (row == LAST_ROW) ? FIN : ISSUE;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Address and strobe are only non-zero while a read is being issued.
    assign busy           = (state != IDLE);
    assign done           = (state == FIN);
    assign gsram_rd_en    = (state == ISSUE);
    assign gsram_addr_row = (state == ISSUE) ? row : '0;
    assign gsram_addr_col = (state == ISSUE) ? col : '0;
    assign out_valid      = (state == SEND);
    assign class_valid    = (state == CLASS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            out_data    <= '0;
            out_row     <= '0;
            out_col     <= '0;
            out_last    <= 1'b0;
            class_row   <= '0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        row <= '0;
                        col <= '0;
                    end
                end
                CAPTURE: begin
                    out_data <= gsram_rdata;
                    out_row  <= row;
                    out_col  <= col;
                    out_last <= (col == LAST_COL);
                    // Strict signed compare: ties keep the lower column.
                    if (col == '0) begin
                        max_q <= $signed(gsram_rdata);
                        idx_q <= '0;
                    end else if ($signed(gsram_rdata) > max_q) begin
                        max_q <= $signed(gsram_rdata);
                        idx_q <= col;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (col == LAST_COL) begin
                            class_row   <= row;
                            class_idx   <= idx_q;
                            class_score <= max_q;
                        end else begin
                            col <= col + 4'd1;
                        end
                    end
                end
                CLASS: begin
                    col <= '0;
                    if (row != LAST_ROW) row <= row + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gsram_result_reader.sv
// Scoreboard bench for gsram_result_reader: GSRAM model, expected beat/class
// queues filled at start, compared as the DUT emits them.
module tb_gsram_result_reader;

    localparam int DATA_W = 16;
    localparam int ROWS   = 10;
    localparam int COLS   = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, gsram_rd_en;
    logic [3:0]        gsram_addr_row, gsram_addr_col;
    logic [DATA_W-1:0] gsram_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_row, out_col;
    logic              out_last;
    logic              class_valid;
    logic [3:0]        class_row, class_idx;
    logic [DATA_W-1:0] class_score;

    gsram_result_reader #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .gsram_rd_en(gsram_rd_en), .gsram_addr_row(gsram_addr_row),
        .gsram_addr_col(gsram_addr_col), .gsram_rdata(gsram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .class_valid(class_valid), .class_row(class_row),
        .class_idx(class_idx), .class_score(class_score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [3:0]        r;
        logic [3:0]        c;
        logic              l;
    } beat_t;

    typedef struct packed {
        logic [3:0]        r;
        logic [3:0]        i;
        logic [DATA_W-1:0] s;
    } cls_t;

    beat_t beat_q[$];
    cls_t  cls_q[$];

    logic [DATA_W-1:0] mem [ROWS][COLS];
    logic [3:0]        seen_idx   [ROWS];
    logic [DATA_W-1:0] seen_score [ROWS];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beats    = 0;
    int classes  = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // GSRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (gsram_rd_en) gsram_rdata <= mem[gsram_addr_row][gsram_addr_col];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 32'd1, 32'd0);
                end else begin
                    check("out_data", 32'(out_data), 32'(beat_q[0].d));
                    check("out_row",  32'(out_row),  32'(beat_q[0].r));
                    check("out_col",  32'(out_col),  32'(beat_q[0].c));
                    check("out_last", 32'(out_last), 32'(beat_q[0].l));
                    if (!out_ready) check("stall_rd_en", 32'(gsram_rd_en), 32'd0);
                    if (out_ready) begin
                        void'(beat_q.pop_front());
                        beats++;
                    end
                end
            end
            if (class_valid) begin
                if (cls_q.size() == 0) begin
                    check("class_unexpected", 32'd1, 32'd0);
                end else begin
                    check("class_row",   32'(class_row),   32'(cls_q[0].r));
                    check("class_idx",   32'(class_idx),   32'(cls_q[0].i));
                    check("class_score", 32'(class_score), 32'(cls_q[0].s));
                    void'(cls_q.pop_front());
                end
                seen_idx[class_row]   = class_idx;
                seen_score[class_row] = class_score;
                classes++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_expected();
        logic signed [DATA_W-1:0] best;
        logic [3:0]               bi;
        for (int unsigned r = 0; r < ROWS; r++) begin
            best = $signed(mem[r][0]);
            bi   = '0;
            for (int unsigned c = 0; c < COLS; c++) begin
                beat_q.push_back('{d: mem[r][c], r: 4'(r), c: 4'(c), l: (c == COLS - 1)});
                if (c > 0 && $signed(mem[r][c]) > best) begin
                    best = $signed(mem[r][c]);
                    bi   = 4'(c);
                end
            end
            cls_q.push_back('{r: 4'(r), i: bi, s: best});
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_rd_en"}, 32'(gsram_rd_en), 32'd0);
        check({tag, "_addr"},  32'({gsram_addr_row, gsram_addr_col}), 32'd0);
        check({tag, "_valid"}, 32'({out_valid, class_valid}), 32'd0);
        check({tag, "_out"},   32'({out_data, out_row, out_col, out_last}), 32'd0);
        check({tag, "_class"}, 32'({class_row, class_idx, class_score}), 32'd0);
    endtask

    // Runs one full sweep; optional backpressure on beat (0,4) and a
    // redundant start pulse once 20 beats have been accepted.
    task automatic run_sweep(input string tag, input bit stall04, input bit restart20);
        int  start_cyc, done0, beats0, cls0, stall_left;
        bit  got_done, stalled, restarted;
        done0 = done_cnt; beats0 = beats; cls0 = classes;
        got_done = 0; stalled = 0; restarted = 0; stall_left = 0;
        push_expected();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc + 1;
        for (int k = 0; k < 450 && !got_done; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (restart20 && !restarted && beats - beats0 == 20) begin
                start     = 1'b1;
                restarted = 1;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end else if (stall04 && !stalled && out_valid && out_row == 4'd0 && out_col == 4'd4) begin
                out_ready  = 1'b0;
                stall_left = 5;
                stalled    = 1;
            end
            if (done_cnt != done0) got_done = 1;
        end
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        // The edge that samples start counts as the first of the 311.
        check({tag, "_done_edges"}, 32'(done_cyc - start_cyc + 1), stall04 ? 32'd316 : 32'd311);
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
        check({tag, "_beats"}, 32'(beats - beats0), 32'd100);
        check({tag, "_classes"}, 32'(classes - cls0), 32'd10);
        check({tag, "_q_empty"}, 32'(beat_q.size() + cls_q.size()), 32'd0);
        if (restart20) check({tag, "_restart_driven"}, 32'(restarted), 32'd1);
        if (stall04)   check({tag, "_stall_driven"}, 32'(stalled), 32'd1);
    endtask

    initial begin
        int  done0;
        bit  hit;

        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;

        // Sweep A: ascending pattern, redundant start mid-sweep.
        for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++)
                mem[r][c] = 16'(r * 16 + c);
        run_sweep("incr", 1'b0, 1'b1);
        for (int unsigned r = 0; r < ROWS; r++)
            check("incr_idx", 32'(seen_idx[r]), 32'd9);

        // Sweep B: signed/tie rows plus backpressure on beat (0,4).
        for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++)
                mem[r][c] = 16'($urandom);
        mem[0] = '{16'(-50), 16'(-3), 16'(-7), 16'(-8), 16'(-9),
                   16'(-10), 16'(-11), 16'(-12), 16'(-13), 16'(-14)};
        mem[3] = '{16'(5), 16'(-2), 16'(40), 16'(40), 16'(7),
                   16'(0), 16'(0), 16'(0), 16'(0), 16'(-100)};
        run_sweep("mixed", 1'b1, 1'b0);
        check("row3_idx",   32'(seen_idx[3]),   32'd2);
        check("row3_score", 32'(seen_score[3]), 32'd40);
        check("row0_idx",   32'(seen_idx[0]),   32'd1);
        check("row0_score", 32'(seen_score[0]), 32'hFFFD);

        // Sweep C: reset during row 6 aborts without done.
        done0 = done_cnt;
        push_expected();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            if (out_valid && out_row == 4'd6) hit = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("abort_reached_row6", 32'(hit), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_zero("abort");
        beat_q.delete();
        cls_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - done0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        run_sweep("fresh", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
